// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment receive path: bus widths and the
// active-high glyph table (bit 0 = a ... bit 6 = g).
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int NIB_W = 4;

  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;

  // Indexed by nibble value: GLYPHS[n] is the pattern for hex digit n.
  localparam logic [15:0][SEG_W-1:0] GLYPHS = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

endpackage

// File: rtl/seg_pat_dec.sv
// Reverse glyph lookup: active-high segment pattern to hex nibble, with a
// hit flag that is low for any pattern outside the 16-glyph table.
module seg_pat_dec
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pat,
  output logic             hit,
  output logic [NIB_W-1:0] nib
);

  always_comb begin
    hit = 1'b0;
    nib = '0;
    for (int i = 0; i < 16; i++) begin
      if (pat == GLYPHS[i]) begin
        hit = 1'b1;
        nib = NIB_W'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_rx.sv
// Multiplexed 7-segment bus monitor: debounces each digit's pattern, decodes
// it back to hex and publishes a full word once every slot has been captured.
module seg7_scan_rx
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYC     = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [SEG_W-1:0]        iSEG7,
  input  logic [DIGITS-1:0]       iDIG_EN,
  input  logic                    iClr,
  output logic [NIB_W*DIGITS-1:0] oValue,
  output logic                    oValid,
  output logic [DIGITS-1:0]       oDigErr,
  output logic                    oBadPat
);

  localparam logic [7:0] RUN_MAX = 8'(STABLE_CYC);

  logic [DIGITS-1:0]       en_p0;
  logic [SEG_W-1:0]        seg_p0;
  logic [7:0]              run_p0;
  logic                    onehot;
  logic                    same;
  logic                    capture;
  logic [7:0]              run_nxt;
  logic [SEG_W-1:0]        pat_hi;
  logic                    dec_hit;
  logic [NIB_W-1:0]        dec_nib;
  logic [DIGITS-1:0]       good_mask;
  logic [DIGITS-1:0]       seen;
  logic [DIGITS-1:0]       seen_nxt;
  logic [DIGITS-1:0]       dig_err;
  logic [NIB_W*DIGITS-1:0] slot;
  logic [NIB_W*DIGITS-1:0] slot_nxt;
  logic [NIB_W*DIGITS-1:0] value;
  logic                    valid;
  logic                    bad_pat;

  function automatic logic is_onehot(input logic [DIGITS-1:0] v);
    return (v != '0) && ((v & (v - DIGITS'(1))) == '0);
  endfunction

  assign pat_hi = SEG_ACTIVE_LOW ? ~iSEG7 : iSEG7;

  seg_pat_dec u_dec (
    .pat (pat_hi),
    .hit (dec_hit),
    .nib (dec_nib)
  );

  // Stage p0: run tracking against the previous sample; the count saturates
  // so a held pattern produces a single capture however long it lasts.
  always_comb begin
    onehot = is_onehot(iDIG_EN);
    same   = onehot && (iDIG_EN == en_p0) && (iSEG7 == seg_p0) && (run_p0 != 8'd0);
    if (!onehot)
      run_nxt = 8'd0;
    else if (!same)
      run_nxt = 8'd1;
    else if (run_p0 >= RUN_MAX)
      run_nxt = RUN_MAX;
    else
      run_nxt = run_p0 + 8'd1;
    capture = onehot && (run_nxt == RUN_MAX) && !(same && (run_p0 == RUN_MAX));
  end

  always_comb begin
    good_mask = (capture && dec_hit) ? iDIG_EN : '0;
    seen_nxt  = seen | good_mask;
    slot_nxt  = slot;
    for (int i = 0; i < DIGITS; i++) begin
      if (good_mask[i])
        slot_nxt[NIB_W*i +: NIB_W] = dec_nib;
    end
  end

  // Stage p1: slot, frame and error registers; iClr discards this edge's capture.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      en_p0   <= '0;
      seg_p0  <= '0;
      run_p0  <= '0;
      seen    <= '0;
      dig_err <= '0;
      slot    <= '0;
      value   <= '0;
      valid   <= 1'b0;
      bad_pat <= 1'b0;
    end else begin
      en_p0   <= onehot ? iDIG_EN : '0;
      seg_p0  <= iSEG7;
      run_p0  <= run_nxt;
      valid   <= 1'b0;
      bad_pat <= 1'b0;
      if (iClr) begin
        seen    <= '0;
        dig_err <= '0;
      end else begin
        if (capture && !dec_hit) begin
          dig_err <= dig_err | iDIG_EN;
          bad_pat <= 1'b1;
        end
        slot <= slot_nxt;
        if (seen_nxt == '1) begin
          value <= slot_nxt;
          valid <= 1'b1;
          seen  <= '0;
        end else begin
          seen <= seen_nxt;
        end
      end
    end
  end

  assign oValue  = value;
  assign oValid  = valid;
  assign oDigErr = dig_err;
  assign oBadPat = bad_pat;

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Directed bench for seg7_scan_rx (DIGITS=4, STABLE_CYC=4, active-low segments).
module tb_seg7_scan_rx;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [6:0]  iSEG7;
  logic [3:0]  iDIG_EN;
  logic        iClr;
  logic [15:0] oValue;
  logic        oValid;
  logic [3:0]  oDigErr;
  logic        oBadPat;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int bad_cnt = 0;

  seg7_scan_rx #(
    .DIGITS         (4),
    .STABLE_CYC     (4),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .iSEG7   (iSEG7),
    .iDIG_EN (iDIG_EN),
    .iClr    (iClr),
    .oValue  (oValue),
    .oValid  (oValid),
    .oDigErr (oDigErr),
    .oBadPat (oBadPat)
  );

  always #5 iCLK = ~iCLK;

  // Present one bus value for n edges; outputs are observed 1ns after each edge.
  task automatic drive(input logic [3:0] en, input logic [6:0] seg, input int n);
    iDIG_EN = en;
    iSEG7   = seg;
    repeat (n) begin
      @(posedge iCLK);
      #1;
      if (oValid)  valid_cnt++;
      if (oBadPat) bad_cnt++;
    end
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    iClr   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iDIG_EN = 4'($urandom);
      iSEG7   = 7'($urandom);
      @(posedge iCLK);
      #1;
      checks++;
      if ({oValue, oValid, oDigErr, oBadPat} !== 22'h0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %h want 0", i,
                 {oValue, oValid, oDigErr, oBadPat});
      end
    end
    iDIG_EN = 4'b0000;
    iRST_N  = 1'b1;
  endtask

  task automatic test_frames();
    valid_cnt = 0;
    drive(4'b0001, 7'h79, 4);
    drive(4'b0010, 7'h24, 4);
    drive(4'b0100, 7'h30, 4);
    checks++;
    if (valid_cnt !== 0) begin
      errors++; $display("FAIL frame1_early_valid got %0d want 0", valid_cnt);
    end
    drive(4'b1000, 7'h19, 3);
    checks++;
    if (oValid !== 1'b0) begin
      errors++; $display("FAIL frame1_edge3_valid got %b want 0", oValid);
    end
    drive(4'b1000, 7'h19, 1);
    checks++;
    if (oValid !== 1'b1) begin
      errors++; $display("FAIL frame1_edge4_valid got %b want 1", oValid);
    end
    checks++;
    if (oValue !== 16'h4321) begin
      errors++; $display("FAIL frame1_value got %h want 4321", oValue);
    end
    drive(4'b1000, 7'h19, 1);
    checks++;
    if (oValid !== 1'b0) begin
      errors++; $display("FAIL frame1_pulse_width got %b want 0", oValid);
    end
    valid_cnt = 0;
    drive(4'b0001, 7'h08, 4);
    drive(4'b0010, 7'h03, 4);
    drive(4'b0100, 7'h46, 4);
    drive(4'b1000, 7'h21, 4);
    checks++;
    if (oValid !== 1'b1 || oValue !== 16'hDCBA) begin
      errors++; $display("FAIL frame2_value got %b/%h want 1/dcba", oValid, oValue);
    end
    checks++;
    if (valid_cnt !== 1) begin
      errors++; $display("FAIL frame2_pulses got %0d want 1", valid_cnt);
    end
  endtask

  task automatic test_run_filter();
    valid_cnt = 0;
    bad_cnt   = 0;
    drive(4'b0001, 7'h79, 3);
    drive(4'b0001, 7'h24, 6);
    drive(4'b0010, 7'h79, 4);
    drive(4'b0100, 7'h24, 4);
    drive(4'b1000, 7'h30, 4);
    checks++;
    if (oValid !== 1'b1 || oValue !== 16'h3212) begin
      errors++; $display("FAIL filter_value got %b/%h want 1/3212", oValid, oValue);
    end
    checks++;
    if (valid_cnt !== 1 || bad_cnt !== 0) begin
      errors++; $display("FAIL filter_pulses got %0d/%0d want 1/0", valid_cnt, bad_cnt);
    end
  endtask

  task automatic test_bad_pattern();
    valid_cnt = 0;
    bad_cnt   = 0;
    drive(4'b0010, 7'h7F, 3);
    checks++;
    if (oBadPat !== 1'b0 || oDigErr !== 4'b0000) begin
      errors++; $display("FAIL bad_early got %b/%b want 0/0000", oBadPat, oDigErr);
    end
    drive(4'b0010, 7'h7F, 1);
    checks++;
    if (oBadPat !== 1'b1 || oDigErr !== 4'b0010 || oValid !== 1'b0) begin
      errors++; $display("FAIL bad_capture got %b/%b/%b want 1/0010/0", oBadPat, oDigErr, oValid);
    end
    drive(4'b0010, 7'h7F, 3);
    checks++;
    if (bad_cnt !== 1 || oDigErr !== 4'b0010 || valid_cnt !== 0) begin
      errors++; $display("FAIL bad_hold got %0d/%b/%0d want 1/0010/0", bad_cnt, oDigErr, valid_cnt);
    end
    iClr = 1'b1;
    drive(4'b0010, 7'h7F, 1);
    iClr = 1'b0;
    checks++;
    if (oDigErr !== 4'b0000) begin
      errors++; $display("FAIL bad_clear got %b want 0000", oDigErr);
    end
  endtask

  task automatic test_illegal_enable();
    valid_cnt = 0;
    bad_cnt   = 0;
    drive(4'b0011, 7'h40, 10);
    drive(4'b0000, 7'h40, 10);
    checks++;
    if (valid_cnt !== 0 || bad_cnt !== 0) begin
      errors++; $display("FAIL illegal_en_pulses got %0d/%0d want 0/0", valid_cnt, bad_cnt);
    end
    drive(4'b0001, 7'h40, 4);
    drive(4'b0010, 7'h40, 4);
    drive(4'b0100, 7'h40, 4);
    drive(4'b1000, 7'h40, 4);
    checks++;
    if (oValid !== 1'b1 || oValue !== 16'h0000 || valid_cnt !== 1) begin
      errors++; $display("FAIL zero_frame got %b/%h/%0d want 1/0000/1", oValid, oValue, valid_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    drive(4'b0001, 7'h79, 4);
    drive(4'b0010, 7'h24, 4);
    drive(4'b0100, 7'h30, 4);
    drive(4'b1000, 7'h19, 4);
    checks++;
    if (oValue !== 16'h4321) begin
      errors++; $display("FAIL pre_reset_value got %h want 4321", oValue);
    end
    drive(4'b0001, 7'h79, 4);
    drive(4'b0010, 7'h24, 4);
    iDIG_EN = 4'b0000;
    iRST_N  = 1'b0;
    @(posedge iCLK);
    #1;
    iRST_N = 1'b1;
    checks++;
    if (oValue !== 16'h0000 || oValid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_value got %h/%b want 0000/0", oValue, oValid);
    end
    valid_cnt = 0;
    drive(4'b0100, 7'h30, 4);
    drive(4'b1000, 7'h19, 4);
    checks++;
    if (valid_cnt !== 0 || oValue !== 16'h0000) begin
      errors++; $display("FAIL partial_after_reset got %0d/%h want 0/0000", valid_cnt, oValue);
    end
  endtask

  task automatic test_clr_on_capture();
    iClr = 1'b1;
    drive(4'b0000, 7'h00, 1);
    iClr = 1'b0;
    valid_cnt = 0;
    drive(4'b0001, 7'h12, 4);
    drive(4'b0010, 7'h02, 4);
    drive(4'b0100, 7'h78, 4);
    drive(4'b1000, 7'h00, 3);
    iClr = 1'b1;
    drive(4'b1000, 7'h00, 1);
    iClr = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oBadPat !== 1'b0) begin
      errors++; $display("FAIL clr_capture got %b/%b want 0/0", oValid, oBadPat);
    end
    drive(4'b1000, 7'h00, 2);
    drive(4'b0000, 7'h00, 1);
    drive(4'b1000, 7'h10, 4);
    checks++;
    if (valid_cnt !== 0) begin
      errors++; $display("FAIL clr_seen_cleared got %0d want 0", valid_cnt);
    end
    drive(4'b0001, 7'h08, 4);
    drive(4'b0010, 7'h03, 4);
    drive(4'b0100, 7'h46, 3);
    checks++;
    if (oValid !== 1'b0) begin
      errors++; $display("FAIL clr_refill_early got %b want 0", oValid);
    end
    drive(4'b0100, 7'h46, 1);
    checks++;
    if (oValid !== 1'b1 || oValue !== 16'h9CBA || valid_cnt !== 1) begin
      errors++; $display("FAIL clr_refill_value got %b/%h/%0d want 1/9cba/1", oValid, oValue, valid_cnt);
    end
  endtask

  initial begin
    iRST_N  = 1'b0;
    iClr    = 1'b0;
    iDIG_EN = 4'b0000;
    iSEG7   = 7'h7F;
    test_reset();
    test_frames();
    test_run_filter();
    test_bad_pattern();
    test_illegal_enable();
    test_reset_mid_frame();
    test_clr_on_capture();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_rx.md
Name: seg7_scan_rx

Overview:
- Receiving end of the 7-segment display interface: watches a multiplexed segment bus (shared segment lines plus one-hot digit enables) and reverse-decodes each digit's pattern back to a hex nibble.
- Requires a pattern to be stable before accepting it, assembles a full multi-digit word, and pulses oValid when every digit slot has been captured.
- Flags patterns that are not valid hex glyphs.
- Used as a self-check monitor beside the display path and in board-level loopback benches.

Parameters:
- DIGITS, 4, number of multiplexed digits; legal range 1..8.
- STABLE_CYC, 4, consecutive identical samples required before a capture; legal range 1..255.
- SEG_ACTIVE_LOW, 1, 1 means a lit segment is driven 0 on iSEG7.

Ports:
- iCLK  input  1  single clock for all logic.
- iRST_N  input  1  synchronous, active-low reset.
- iSEG7  input  7  segment lines; bit 0 = a … bit 6 = g.
- iDIG_EN  input  DIGITS  active-high digit select; only one-hot values are legal.
- iClr  input  1  synchronous clear of the partial frame and error flags.
- oValue  output  4*DIGITS  assembled word; digit i maps to bits [4i+3:4i].
- oValid  output  1  one-cycle pulse when oValue is updated.
- oDigErr  output  DIGITS  sticky per-slot invalid-pattern flag.
- oBadPat  output  1  one-cycle pulse for each invalid-pattern capture.

Behaviour:
- Reset is synchronous, active-low, and sampled on iCLK. While iRST_N=0:
  - oValue=0, oValid=0, oDigErr=0, oBadPat=0.
  - Slot registers and seen[] are cleared.
  - The run tracker is cleared (previous sample = enable 0).
- All outputs are registered.
- Run tracking:
  - A run is consecutive edges with identical {iDIG_EN, iSEG7} where iDIG_EN is one-hot.
  - A zero or multi-hot iDIG_EN ends any run and starts none.
- Capture:
  - Exactly one capture per run, at the edge where run length reaches STABLE_CYC.
  - Example, STABLE_CYC=4: input presented before edges 1..4 is captured at edge 4.
  - A run longer than STABLE_CYC does not re-capture.
- Decode:
  - Normalise to active-high (invert when SEG_ACTIVE_LOW=1).
  - Valid patterns: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - Any other pattern is invalid.
- Valid capture on slot i:
  - slot[i] is written with the nibble and seen[i] is set.
  - Re-capturing a slot that is already seen overwrites it; seen stays set.
- Invalid capture on slot i:
  - slot[i] and seen[i] are unchanged.
  - oDigErr[i] is set and oBadPat pulses for 1 cycle.
- Frame completion:
  - When seen (including this edge's capture) is all ones, oValue is updated at the same edge from the slot registers (including the new nibble).
  - oValid=1 for exactly that cycle, and seen clears.
  - oValue holds its value between frames.
- iClr=1:
  - seen and oDigErr clear.
  - Any capture at that edge is discarded: no slot write, no oBadPat, no oValid.
  - Run tracking continues unaffected.
- DIGITS=1: every valid capture produces an oValid pulse.
- Reset mid-frame discards the partial frame; oValue returns to 0.
- Run counter is 8 bits and saturates at STABLE_CYC.

Decomposition:
- Shared package seg7_pkg holds:
  - The 16 active-high glyph constants.
  - SEG_W=7 and NIB_W=4.
- Natural sub-module seg_pat_dec, combinational: 7-bit active-high pattern -> {hit, nibble[3:0]}, one instance.
- Run tracker, slot registers and frame logic live in the top level.

Test Plan (DIGITS=4, STABLE_CYC=4, SEG_ACTIVE_LOW=1):
1. Hold iRST_N=0 for 3 cycles with random bus activity -> oValue=0, oValid=0, oDigErr=0, oBadPat=0 throughout.
2. Enables 0001..1000 in turn, 4 cycles each, patterns 0x79, 0x24, 0x30, 0x19 -> single oValid pulse at the 4th edge of digit 3, oValue=16'h4321. Repeat with 0x08, 0x03, 0x46, 0x21 -> oValue=16'hDCBA.
3. Digit 0: 0x79 for 3 cycles, then 0x24 for 6 cycles -> only "2" captured (at the 4th 0x24 edge); no second capture. Complete the frame with 1, 2, 3 -> oValue=16'h3212.
4. Digit 1: 0x7F (blank) for 4 cycles -> oBadPat pulse at edge 4, oDigErr=4'b0010, no oValid. Pulse iClr -> oDigErr=0.
5. iDIG_EN=4'b0011 then 4'b0000, each for 10 cycles with 0x40 -> no capture, no pulses. Then a full frame of 0x40 -> oValue=16'h0000 with oValid pulse.
6. Capture digits 0 and 1, pulse iRST_N=0 for 1 cycle, then capture digits 2 and 3 only -> no oValid.
7. Capture digits 0..2, then assert iClr on the capture edge of digit 3 -> no oValid, seen=0, next full frame required.
